fetch_stage: RTL and testbench

Instruction-fetch stage of the pipelined CPU. Holds the program counter and issues one-at-a-time requests to instruction memory, which has variable latency. Returned instruction words go into a 2-entry buffer with their PC, and the buffer feeds the IF/ID pipeline register through a valid/ready handshake. Branch redirects from later stages flush the buffer and discard any in-flight fetch.

---
 rtl/fetch_stage.sv | 127 ++++++++++++
 tb/tb_fetch_stage.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, one-outstanding variable-latency imem fetch,
// 2-entry {instr, pc} output buffer and redirect flush handling.
module fetch_stage #(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [63:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [63:0] out_pc
);

    typedef enum logic [1:0] {FETCH, WAIT, DRAIN} state_e;

    state_e      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic [63:0] req_pc_q, req_pc_d;
    logic [31:0] buf_instr_q [2];
    logic [63:0] buf_pc_q [2];
    logic        head_q, head_d;
    logic        tail_q, tail_d;
    logic [1:0]  count_q, count_d;
    logic        push;
    logic        pop;
    logic        req_fire;
    logic        unused_redirect_lsbs;

    // Requests are gated by reset so nothing is offered while held in reset,
    // and by redirect so a stale PC is never accepted.
    assign imem_req_valid = reset && (state_q == FETCH) && (count_q < 2'd2) && !redirect_valid;
    assign imem_addr      = pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign out_valid = (count_q != 2'd0);
    assign out_instr = buf_instr_q[head_q];
    assign out_pc    = buf_pc_q[head_q];

    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
        head_d   = head_q;
        tail_d   = tail_q;
        count_d  = count_q;
        push     = 1'b0;
        pop      = 1'b0;
        if (redirect_valid) begin
            pc_d    = {redirect_pc[63:2], 2'b00};
            head_d  = 1'b0;
            tail_d  = 1'b0;
            count_d = 2'd0;
            // A fetch still in flight must have its response swallowed.
            if ((state_q != FETCH) && !imem_rsp_valid) begin
                state_d = DRAIN;
            end else begin
                state_d = FETCH;
            end
        end else begin
            pop = out_valid && out_ready;
            case (state_q)
                FETCH: begin
                    if (req_fire) begin
                        req_pc_d = pc_q;
                        state_d  = WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rsp_valid) begin
                        push    = 1'b1;
                        pc_d    = req_pc_q + 64'd4;
                        state_d = FETCH;
                    end
                end
                DRAIN: begin
                    if (imem_rsp_valid) begin
                        state_d = FETCH;
                    end
                end
                default: state_d = FETCH;
            endcase
            if (push) begin
                tail_d = ~tail_q;
            end
            if (pop) begin
                head_d = ~head_q;
            end
            count_d = count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= FETCH;
            pc_q           <= RESET_PC;
            req_pc_q       <= '0;
            head_q         <= 1'b0;
            tail_q         <= 1'b0;
            count_q        <= 2'd0;
            buf_instr_q[0] <= '0;
            buf_instr_q[1] <= '0;
            buf_pc_q[0]    <= '0;
            buf_pc_q[1]    <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            if (push) begin
                buf_instr_q[tail_q] <= imem_rsp_data;
                buf_pc_q[tail_q]    <= req_pc_q;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: variable-latency imem responder, expected-stream
// scoreboard of sequential PCs per redirect segment, directed timing checks.
module tb_fetch_stage;

    localparam logic [63:0] RST_PC = 64'h100;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [63:0] imem_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_instr;
    logic [63:0] out_pc;

    always #5 clk = ~clk;

    fetch_stage #(.RESET_PC(RST_PC)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc)
    );

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t        exp_q [$];
    logic [63:0] exp_next = RST_PC;
    int          n_checks = 0;
    int          n_pass = 0;
    int          pop_cnt = 0;

    logic        rand_ready = 1'b0;
    logic        hold_ready = 1'b0;
    int          lat_fixed = 1;
    logic        pend = 1'b0;
    int          wait_cnt = 0;
    logic [63:0] pend_addr = '0;
    logic        prev_redir = 1'b0;

    logic [63:0] hs_addr [4];
    int          n_hs;
    logic [63:0] tgt;
    logic        last_r;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'h5A3C_96E1;
    endfunction

    task automatic check(input string name, input logic ok, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    endtask

    task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] req);
        check(name, act === req, act, req);
    endtask

    // Expected output stream: consecutive words from the current segment start.
    task automatic refill();
        exp_t e;
        while (exp_q.size() < 6) begin
            e.pc    = exp_next;
            e.instr = mem_word(exp_next);
            exp_q.push_back(e);
            exp_next = exp_next + 64'd4;
        end
    endtask

    task automatic restart_model(input logic [63:0] start);
        exp_q.delete();
        exp_next = {start[63:2], 2'b00};
        refill();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        refill();
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic redirect(input logic [63:0] t);
        redirect_valid = 1'b1;
        redirect_pc    = t;
        restart_model(t);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        restart_model(RST_PC);
        repeat (6) tick();
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_out_pc", out_pc, 64'd0);
        check_eq("rst_out_instr", 64'(out_instr), 64'd0);
        check_eq("rst_req_valid", 64'(imem_req_valid), 64'd0);
        check_eq("rst_imem_addr", imem_addr, RST_PC);
        reset = 1'b1;
    endtask

    // Instruction memory: one response per accepted request, k cycles later.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            imem_rsp_valid = 1'b0;
            if (pend) begin
                if (wait_cnt <= 1) begin
                    imem_rsp_valid = 1'b1;
                    imem_rsp_data  = mem_word(pend_addr);
                    pend = 1'b0;
                end else begin
                    wait_cnt--;
                end
            end
            imem_req_ready = hold_ready ? 1'b0 : (rand_ready ? (($urandom % 10) < 7) : 1'b1);
            @(negedge clk);
            if (reset && imem_req_valid && imem_req_ready) begin
                check("one_outstanding", !pend, 64'(pend), 64'd0);
                pend      = 1'b1;
                pend_addr = imem_addr;
                wait_cnt  = (lat_fixed > 0) ? lat_fixed : int'($urandom_range(4, 1));
            end
        end
    end

    // Monitor: every accepted output word is the next one the model predicts.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            if (prev_redir) check_eq("flush_out_valid", 64'(out_valid), 64'd0);
            if (redirect_valid) check_eq("req_in_redirect", 64'(imem_req_valid), 64'd0);
            if (imem_req_valid) check_eq("addr_align", 64'(imem_addr[1:0]), 64'd0);
            if (out_valid && out_ready && !redirect_valid) begin
                if (exp_q.size() == 0) begin
                    check("pop_unexpected", 1'b0, out_pc, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("out_pc", out_pc, e.pc);
                    check_eq("out_instr", 64'(out_instr), 64'(e.instr));
                    pop_cnt++;
                end
            end
            prev_redir = redirect_valid;
        end else begin
            prev_redir = 1'b0;
        end
    end

    initial begin
        // Sequential fetch, k=1, no stall
        rand_ready = 1'b0; lat_fixed = 1; out_ready = 1'b1;
        do_reset();
        for (int c = 0; c < 8; c++) begin
            at_neg();
            if (c == 0) begin
                check_eq("t1_req0_valid", 64'(imem_req_valid), 64'd1);
                check_eq("t1_req0_addr", imem_addr, 64'h100);
                check_eq("t1_out0_valid", 64'(out_valid), 64'd0);
            end
            if (c == 1) check_eq("t1_wait_noreq", 64'(imem_req_valid), 64'd0);
            if (c == 2 || c == 4) begin
                check_eq("t1_out_valid", 64'(out_valid), 64'd1);
                check_eq("t1_out_pc", out_pc, (c == 2) ? 64'h100 : 64'h104);
                check_eq("t1_req_valid", 64'(imem_req_valid), 64'd1);
                check_eq("t1_req_addr", imem_addr, (c == 2) ? 64'h104 : 64'h108);
            end
            tick();
        end

        // Stall: only two fetches ahead, resume when a slot frees
        out_ready = 1'b0; lat_fixed = 1;
        do_reset();
        n_hs = 0;
        hs_addr = '{default: 64'd0};
        for (int c = 0; c < 10; c++) begin
            at_neg();
            if (imem_req_valid && imem_req_ready) begin
                if (n_hs < 4) hs_addr[n_hs] = imem_addr;
                n_hs++;
            end
            tick();
        end
        check_eq("t2_fetch_count", 64'(n_hs), 64'd2);
        check_eq("t2_fetch0", hs_addr[0], 64'h100);
        check_eq("t2_fetch1", hs_addr[1], 64'h104);
        at_neg();
        check_eq("t2_stalled", 64'(imem_req_valid), 64'd0);
        tick();
        out_ready = 1'b1;
        at_neg();
        check_eq("t2_still_full", 64'(imem_req_valid), 64'd0);
        tick();
        at_neg();
        check_eq("t2_resume_valid", 64'(imem_req_valid), 64'd1);
        check_eq("t2_resume_addr", imem_addr, 64'h108);
        repeat (8) begin tick(); at_neg(); end

        // Redirect while 0x104 is outstanding, k=3
        out_ready = 1'b1; lat_fixed = 3;
        do_reset();
        repeat (5) begin at_neg(); tick(); end
        redirect(64'h2000);
        at_neg();
        tick(); at_neg();
        check_eq("t3_out_flushed", 64'(out_valid), 64'd0);
        check_eq("t3_drain_noreq", 64'(imem_req_valid), 64'd0);
        tick(); at_neg();
        check_eq("t3_drain_noreq2", 64'(imem_req_valid), 64'd0);
        tick(); at_neg();
        check_eq("t3_new_req_valid", 64'(imem_req_valid), 64'd1);
        check_eq("t3_new_req_addr", imem_addr, 64'h2000);
        repeat (12) begin tick(); at_neg(); end

        // Redirect in the same cycle as the response
        out_ready = 1'b1; lat_fixed = 3;
        do_reset();
        repeat (7) begin at_neg(); tick(); end
        redirect(64'h4000);
        at_neg();
        tick(); at_neg();
        check_eq("t4_req_valid", 64'(imem_req_valid), 64'd1);
        check_eq("t4_req_addr", imem_addr, 64'h4000);
        repeat (10) begin tick(); at_neg(); end

        // Misaligned redirect with a full buffer and out_ready high
        out_ready = 1'b0; lat_fixed = 1;
        do_reset();
        repeat (6) begin at_neg(); tick(); end
        check_eq("t5_full_valid", 64'(out_valid), 64'd1);
        out_ready = 1'b1;
        redirect(64'h3003);
        at_neg();
        tick(); at_neg();
        check_eq("t5_flushed", 64'(out_valid), 64'd0);
        check_eq("t5_req_valid", 64'(imem_req_valid), 64'd1);
        check_eq("t5_req_addr", imem_addr, 64'h3000);
        repeat (8) begin tick(); at_neg(); end

        // PC wraps past the top of the address space
        out_ready = 1'b1; lat_fixed = 1;
        do_reset();
        repeat (2) begin at_neg(); tick(); end
        redirect(64'hFFFF_FFFF_FFFF_FFFC);
        at_neg();
        tick(); at_neg();
        check_eq("t6_req_top", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        tick(); at_neg();
        tick(); at_neg();
        check_eq("t6_wrap_valid", 64'(imem_req_valid), 64'd1);
        check_eq("t6_wrap_addr", imem_addr, 64'd0);
        repeat (8) begin tick(); at_neg(); end

        // Reset asserted while a fetch is outstanding
        out_ready = 1'b0; lat_fixed = 4;
        do_reset();
        repeat (6) begin at_neg(); tick(); end
        hold_ready = 1'b1;
        at_neg(); tick();
        check_eq("t7_pre_valid", 64'(out_valid), 64'd1);
        reset = 1'b0;
        restart_model(RST_PC);
        #1;
        check_eq("t7_async_valid", 64'(out_valid), 64'd0);
        check_eq("t7_async_pc", out_pc, 64'd0);
        check_eq("t7_async_instr", 64'(out_instr), 64'd0);
        check_eq("t7_async_req", 64'(imem_req_valid), 64'd0);
        check_eq("t7_async_addr", imem_addr, RST_PC);
        tick();
        reset = 1'b1;
        at_neg();
        check_eq("t7_restart_valid", 64'(imem_req_valid), 64'd1);
        check_eq("t7_restart_addr", imem_addr, RST_PC);
        tick(); at_neg();
        tick(); at_neg();
        check_eq("t7_late_dropped", 64'(out_valid), 64'd0);
        hold_ready = 1'b0;
        out_ready = 1'b1;
        repeat (14) begin tick(); at_neg(); end

        // Randomized traffic: latency, imem backpressure, stalls, redirects
        rand_ready = 1'b1; lat_fixed = 0; out_ready = 1'b1;
        do_reset();
        last_r = 1'b0;
        for (int c = 0; c < 2500; c++) begin
            out_ready = ($urandom % 10) < 6;
            if (!last_r && (($urandom % 25) == 0)) begin
                case ($urandom % 3)
                    0: tgt = {$urandom, $urandom};
                    1: tgt = 64'h8000 + 64'($urandom % 256);
                    default: tgt = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom % 16);
                endcase
                redirect(tgt);
                last_r = 1'b1;
            end else begin
                last_r = 1'b0;
            end
            at_neg();
            tick();
        end
        out_ready = 1'b1;
        repeat (20) begin at_neg(); tick(); end
        check("enough_traffic", pop_cnt > 100, 64'(pop_cnt), 64'd100);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
